sar_adc_ctrl_mc: RTL and testbench
==================================

Name: sar_adc_ctrl_mc

Overview:
Parametrised multi-channel SAR ADC controller. It is the successor of the single-channel 4-bit SAR FSM. It drives the sample switch, the analog channel mux select and the capacitive DAC code, and it reads the comparator.
- Adds channel scanning with a per-scan channel mask.
- Adds a programmable sample phase length.
- Adds power-of-two oversampling/averaging and continuous scan mode.
- Adds a valid/ready result interface toward the digital back end.
- It sits between the ngspice-cosimulated analog front end (comparator, DAC, mux) and the result consumer.

Parameters:
RESOLUTION, 8, bits per conversion (>=2)
NUM_CH, 4, analog input channels (>=1)
SAMPLE_CYCLES, 2, clock cycles sample_o is held high per conversion (>=1)
AVG_MAX, 3, maximum log2 averaging factor (>=0)
DAC_INV, 0, 1 = dac_o driven bit-inverted (active-low DAC switches)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start scan (level-sampled in IDLE)
ch_mask_i  in  NUM_CH  channels to convert, latched at start
avg_log2_i  in  CW=$clog2(AVG_MAX+1) (min 1)  log2 of samples averaged per result, latched at start
cont_i  in  1  continuous mode, restart scan after last channel
comp_i  in  1  comparator: 1 = DAC level above input
sample_o  out  1  sample switch closed
ch_sel_o  out  CHW=max(1,$clog2(NUM_CH))  mux select
dac_o  out  RESOLUTION  DAC code (inverted if DAC_INV)
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  RESOLUTION  averaged result
result_ch_o  out  CHW  channel of result_o
busy_o  out  1  scan in progress
done_o  out  1  one-cycle pulse, scan finished

Behaviour:
Reset (async, rst_ni=0): state IDLE; sample_o=0, ch_sel_o=0, dac_o=0 (all ones if DAC_INV), valid_o=0, result_o=0, result_ch_o=0, busy_o=0, done_o=0; accumulator, counters and latched mask/avg cleared.
- Reset mid-scan aborts the scan immediately with no output.

States IDLE, SAMPLE, CONVERT, ACCUM, OUTPUT.

IDLE:
- On start_i=1 with ch_mask_i!=0: latch the mask and avg (avg_log2_i > AVG_MAX clamps to AVG_MAX); select the lowest set channel; go to SAMPLE.
- start_i=1 with mask 0 is ignored.
- busy_o=0 only in IDLE.
- start_i outside IDLE is ignored.

SAMPLE:
- sample_o=1 and ch_sel_o=current channel for exactly SAMPLE_CYCLES cycles; code=0.
- Then go to CONVERT with code=1<<(RESOLUTION-1) and trial bit k=RESOLUTION-1.

CONVERT: one bit per cycle, RESOLUTION cycles.
- If comp_i=1, clear bit k; else keep it.
- If k>0, set bit k-1 and decrement k.
- The cycle with k=0 finalises the code and goes to ACCUM.
- dac_o reflects the registered code.

ACCUM:
- acc (RESOLUTION+AVG_MAX bits, no overflow possible) += code; increment the sample count.
- If count < 2^avg, go to SAMPLE on the same channel.
- Else result = acc >> avg (floor); clear acc and count; go to OUTPUT.

OUTPUT:
- valid_o=1, with result_o and result_ch_o stable until the cycle ready_i=1. ready_i may be high before valid_o.
- On handshake, clear valid_o. Then:
  - Next higher set channel in the latched mask → SAMPLE on that channel.
  - Else if cont_i=1 → SAMPLE on the lowest set channel (mask/avg not re-latched).
  - Else → IDLE with done_o=1 for one cycle.
- Conversion stalls (no sampling) while valid_o is held high.

Latency (avg=0): start_i sampled at edge 0 → valid_o high after edge SAMPLE_CYCLES+RESOLUTION+1.
- Each additional averaged sample adds SAMPLE_CYCLES+RESOLUTION+1 cycles.

Edge cases:
- cont_i dropped mid-scan: finish the current scan, then IDLE.
- NUM_CH=1: ch_sel_o is constant 0.
- Comparator always 1 gives code 0; always 0 gives all ones.

Test Plan:
Defaults, comparator model comp_i=(dac code > vin), single channel ch0, vin=0xA5, avg=0 → valid_o after 11 cycles, result_o=0xA5, result_ch_o=0, dac trial sequence 80,C0,A0,B0,A8,A4,A6,A5, done_o pulse after handshake.

Mask 4'b1010, vin ch1=0x10, ch3=0xFF → two results in order (ch1,0x10), (ch3,0xFF); ch_sel_o=1 then 3; channels 0 and 2 never selected.

avg_log2_i=2, vin alternating 0x40,0x41,0x43,0x44 per sample → sum 0x108, result_o=0x42; sample_o pulses 4 times; avg_log2_i=7 clamps to 3 (8 samples).

Backpressure: ready_i=0 for 20 cycles → valid_o, result_o and result_ch_o held, no sample_o activity; ready_i=1 → next channel starts the following cycle.

cont_i=1, mask 4'b0001 → repeated results without new start_i; drop cont_i → one more result, done_o, IDLE. start_i with mask 0 → stays IDLE, busy_o=0.

rst_ni low during CONVERT bit 4 → all outputs at reset values asynchronously; after release, a new start yields a correct result.

Source files
------------

// File: rtl/sar_adc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// sar_adc_ctrl_mc : multi-channel SAR ADC controller with channel scanning,
//                   power-of-two averaging and a valid/ready result port.
// Revision 1.0 - initial release
// ============================================================================
module sar_adc_ctrl_mc #(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CH        = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int AVG_MAX       = 3,
    parameter int DAC_INV       = 0,
    localparam int CW  = (AVG_MAX < 1) ? 1 : $clog2(AVG_MAX + 1),
    localparam int CHW = (NUM_CH < 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [NUM_CH-1:0]     ch_mask_i,
    input  logic [CW-1:0]         avg_log2_i,
    input  logic                  cont_i,
    input  logic                  comp_i,
    output logic                  sample_o,
    output logic [CHW-1:0]        ch_sel_o,
    output logic [RESOLUTION-1:0] dac_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [RESOLUTION-1:0] result_o,
    output logic [CHW-1:0]        result_ch_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int KW   = $clog2(RESOLUTION);
    localparam int SCW  = (SAMPLE_CYCLES < 2) ? 1 : $clog2(SAMPLE_CYCLES);
    localparam int CNTW = AVG_MAX + 1;
    localparam int AW   = RESOLUTION + AVG_MAX;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CONVERT = 3'd2,
        S_ACCUM   = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [CW-1:0]         avg_q, avg_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [RESOLUTION-1:0] code_q, code_d;
    logic [KW-1:0]         bit_q, bit_d;
    logic [SCW-1:0]        scnt_q, scnt_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [RESOLUTION-1:0] result_q, result_d;
    logic [CHW-1:0]        rch_q, rch_d;
    logic                  done_q, done_d;

    logic [AW-1:0]         acc_sum;
    logic [CNTW-1:0]       cnt_inc;
    logic [NUM_CH-1:0]     above;
    logic                  has_next;

    function automatic logic [CHW-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CHW'(i);
        end
    endfunction

    // Channels of the latched mask strictly above the current one.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            above[i] = mask_q[i] && (i > int'(ch_q));
        end
    end

    assign has_next = |above;
    assign acc_sum  = acc_q + AW'(code_q);
    assign cnt_inc  = cnt_q + CNTW'(1);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        avg_d    = avg_q;
        ch_d     = ch_q;
        code_d   = code_q;
        bit_d    = bit_q;
        scnt_d   = scnt_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        rch_d    = rch_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && (|ch_mask_i)) begin
                    mask_d = ch_mask_i;
                    if (int'(avg_log2_i) > AVG_MAX) avg_d = CW'(AVG_MAX);
                    else                            avg_d = avg_log2_i;
                    ch_d    = lowest_ch(ch_mask_i);
                    acc_d   = '0;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    code_d  = '0;
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
                    scnt_d                 = '0;
                    code_d                 = '0;
                    code_d[RESOLUTION-1]   = 1'b1;
                    bit_d                  = KW'(RESOLUTION - 1);
                    state_d                = S_CONVERT;
                end else begin
                    scnt_d = scnt_q + SCW'(1);
                end
            end

            // Comparator high means the trial level overshoots the input.
            S_CONVERT: begin
                if (comp_i) code_d[bit_q] = 1'b0;
                if (bit_q != '0) begin
                    code_d[bit_q - KW'(1)] = 1'b1;
                    bit_d                  = bit_q - KW'(1);
                end else begin
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (cnt_inc < (CNTW'(1) << avg_q)) begin
                    acc_d   = acc_sum;
                    cnt_d   = cnt_inc;
                    code_d  = '0;
                    state_d = S_SAMPLE;
                end else begin
                    result_d = RESOLUTION'(acc_sum >> avg_q);
                    rch_d    = ch_q;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_OUTPUT;
                end
            end

            // Holding here while the consumer stalls keeps the front end idle.
            S_OUTPUT: begin
                if (ready_i) begin
                    code_d = '0;
                    if (has_next) begin
                        ch_d    = lowest_ch(above);
                        state_d = S_SAMPLE;
                    end else if (cont_i) begin
                        ch_d    = lowest_ch(mask_q);
                        state_d = S_SAMPLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            avg_q    <= '0;
            ch_q     <= '0;
            code_q   <= '0;
            bit_q    <= '0;
            scnt_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rch_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            avg_q    <= avg_d;
            ch_q     <= ch_d;
            code_q   <= code_d;
            bit_q    <= bit_d;
            scnt_q   <= scnt_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rch_q    <= rch_d;
            done_q   <= done_d;
        end
    end

    assign sample_o    = (state_q == S_SAMPLE);
    assign valid_o     = (state_q == S_OUTPUT);
    assign busy_o      = (state_q != S_IDLE);
    assign ch_sel_o    = ch_q;
    assign result_o    = result_q;
    assign result_ch_o = rch_q;
    assign done_o      = done_q;

    generate
        if (DAC_INV != 0) begin : g_dac_inv
            assign dac_o = ~code_q;
        end else begin : g_dac_direct
            assign dac_o = code_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl_mc.sv
`default_nettype none
// ============================================================================
// tb_sar_adc_ctrl_mc : scoreboard bench for sar_adc_ctrl_mc with a behavioural
//                      comparator (comp = DAC code > channel input level).
// Revision 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl_mc;

    localparam int RES  = 8;
    localparam int NCH  = 4;
    localparam int SC   = 2;
    localparam int AVGM = 3;
    localparam int DINV = 0;
    localparam int CW   = 2;
    localparam int CHW  = 2;

    logic            clk_i      = 1'b0;
    logic            rst_ni     = 1'b0;
    logic            start_i    = 1'b0;
    logic [NCH-1:0]  ch_mask_i  = '0;
    logic [CW-1:0]   avg_log2_i = '0;
    logic            cont_i     = 1'b0;
    logic            ready_i    = 1'b0;
    logic            comp_i;
    logic            sample_o;
    logic [CHW-1:0]  ch_sel_o;
    logic [RES-1:0]  dac_o;
    logic            valid_o;
    logic [RES-1:0]  result_o;
    logic [CHW-1:0]  result_ch_o;
    logic            busy_o;
    logic            done_o;

    sar_adc_ctrl_mc #(
        .RESOLUTION    (RES),
        .NUM_CH        (NCH),
        .SAMPLE_CYCLES (SC),
        .AVG_MAX       (AVGM),
        .DAC_INV       (DINV)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .ch_mask_i   (ch_mask_i),
        .avg_log2_i  (avg_log2_i),
        .cont_i      (cont_i),
        .comp_i      (comp_i),
        .sample_o    (sample_o),
        .ch_sel_o    (ch_sel_o),
        .dac_o       (dac_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .result_ch_o (result_ch_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [CHW+RES-1:0] exp_q[$];
    logic [7:0] vin [NCH] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] seq [4]   = '{8'h40, 8'h41, 8'h43, 8'h44};
    logic [7:0] trial [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    logic       use_seq   = 1'b0;
    int         spulses   = 0;
    int         sel_cnt [NCH] = '{0, 0, 0, 0};

    logic [RES-1:0] dac_code;
    logic [7:0]     cur_vin;
    always_comb begin
        dac_code = (DINV != 0) ? ~dac_o : dac_o;
        cur_vin  = use_seq ? seq[2'(spulses - 1)] : vin[ch_sel_o];
        comp_i   = (dac_code > cur_vin);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge sample_o);
        spulses++;
    end

    // Monitor: pops one expected result per handshake.
    initial forever begin
        logic [CHW+RES-1:0] e;
        @(negedge clk_i);
        if (rst_ni && sample_o) sel_cnt[ch_sel_o]++;
        if (rst_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {result_ch_o, result_o}, '1);
            end else begin
                e = exp_q.pop_front();
                chk("result", result_o, e[RES-1:0]);
                chk("result_ch", result_ch_o, e[CHW+RES-1:RES]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic start_scan(input logic [NCH-1:0] m, input logic [CW-1:0] a, input logic c);
        @(posedge clk_i); #1;
        ch_mask_i  = m;
        avg_log2_i = a;
        cont_i     = c;
        start_i    = 1'b1;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!valid_o && n < max) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, valid_o, 1);
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy_o && n < max) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, busy_o, 0);
    endtask

    task automatic ready_pulse();
        @(posedge clk_i); #1 ready_i = 1'b1;
        @(posedge clk_i); #1 ready_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_sample"}, sample_o, 0);
        chk({name, "_ch_sel"}, ch_sel_o, 0);
        chk({name, "_dac"}, dac_o, (DINV != 0) ? 32'hFF : 32'h0);
        chk({name, "_valid"}, valid_o, 0);
        chk({name, "_result"}, result_o, 0);
        chk({name, "_result_ch"}, result_ch_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_done"}, done_o, 0);
    endtask

    initial begin
        int base;
        int snap [NCH];

        #12;
        chk_reset_outputs("reset");
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // Single channel, SAR trial sequence and latency.
        vin[0] = 8'hA5;
        exp_q.push_back({2'd0, 8'hA5});
        start_scan(4'b0001, 2'd0, 1'b0);
        @(negedge clk_i);
        chk("t1_sample0", sample_o, 1);
        chk("t1_busy", busy_o, 1);
        @(negedge clk_i);
        chk("t1_sample1", sample_o, 1);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk_i);
            chk("t1_dac_trial", dac_o, trial[t]);
        end
        @(negedge clk_i);
        chk("t1_valid_edge10", valid_o, 0);
        @(negedge clk_i);
        chk("t1_valid_edge11", valid_o, 1);
        ready_pulse();
        @(negedge clk_i);
        chk("t1_done", done_o, 1);
        chk("t1_idle", busy_o, 0);
        @(negedge clk_i);
        chk("t1_done_pulse", done_o, 0);

        // Sparse mask scan.
        vin[1] = 8'h10;
        vin[3] = 8'hFF;
        ready_i = 1'b1;
        exp_q.push_back({2'd1, 8'h10});
        exp_q.push_back({2'd3, 8'hFF});
        snap = sel_cnt;
        start_scan(4'b1010, 2'd0, 1'b0);
        wait_idle(200, "t2_idle");
        chk("t2_sel_ch0", sel_cnt[0] - snap[0], 0);
        chk("t2_sel_ch1", sel_cnt[1] - snap[1], SC);
        chk("t2_sel_ch2", sel_cnt[2] - snap[2], 0);
        chk("t2_sel_ch3", sel_cnt[3] - snap[3], SC);

        // Averaging: four samples of 40,41,43,44 sum to 0x108, mean 0x42.
        use_seq = 1'b1;
        exp_q.push_back({2'd0, 8'h42});
        base = spulses;
        start_scan(4'b0001, 2'd2, 1'b0);
        wait_idle(200, "t3_idle");
        chk("t3_pulses", spulses - base, 4);
        // A request of 7 arrives as all-ones on the 2-bit port and saturates at AVG_MAX=3.
        exp_q.push_back({2'd0, 8'h42});
        base = spulses;
        start_scan(4'b0001, 2'b11, 1'b0);
        wait_idle(400, "t3_idle8");
        chk("t3_pulses8", spulses - base, 8);
        use_seq = 1'b0;

        // Backpressure.
        vin[0] = 8'h33;
        vin[1] = 8'hCC;
        ready_i = 1'b0;
        exp_q.push_back({2'd0, 8'h33});
        exp_q.push_back({2'd1, 8'hCC});
        start_scan(4'b0011, 2'd0, 1'b0);
        wait_valid(100, "t4_valid");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk("t4_hold", {valid_o, sample_o, result_o, result_ch_o}, {1'b1, 1'b0, 8'h33, 2'd0});
        end
        @(posedge clk_i); #1 ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t4_next_sample", sample_o, 1);
        chk("t4_next_ch", ch_sel_o, 1);
        wait_idle(100, "t4_idle");
        ready_i = 1'b0;

        // Continuous mode, then drop cont_i.
        vin[0] = 8'h5A;
        repeat (3) exp_q.push_back({2'd0, 8'h5A});
        start_scan(4'b0001, 2'd0, 1'b1);
        wait_valid(100, "t5_valid1");
        ready_pulse();
        chk("t5_busy1", busy_o, 1);
        wait_valid(100, "t5_valid2");
        ready_pulse();
        chk("t5_busy2", busy_o, 1);
        cont_i = 1'b0;
        wait_valid(100, "t5_valid3");
        ready_pulse();
        @(negedge clk_i);
        chk("t5_done", done_o, 1);
        chk("t5_idle", busy_o, 0);
        repeat (15) @(negedge clk_i);
        chk("t5_stay_idle", {busy_o, valid_o}, 2'b00);

        // Empty mask is ignored.
        start_scan(4'b0000, 2'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("mask0_idle", {busy_o, sample_o, valid_o}, 3'b000);
        end

        // Asynchronous reset during conversion bit 4 (input 0x77 -> code 0x70 at that point).
        vin[2] = 8'h77;
        ready_i = 1'b1;
        start_scan(4'b0100, 2'd0, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        chk("t6_pre_rst_dac", dac_o, 8'h70);
        chk("t6_pre_rst_ch", ch_sel_o, 2);
        #1 rst_ni = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        @(posedge clk_i); #1 rst_ni = 1'b1;
        exp_q.push_back({2'd2, 8'h77});
        start_scan(4'b0100, 2'd0, 1'b0);
        wait_idle(100, "t6_idle");

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
